pi_pdc_chain_ctrl: RTL and testbench

PI_PDC_CHAIN_CTRL -- requirements
Module: pi_pdc_chain_ctrl

---
 rtl/pi_pdc_chain_ctrl_if.sv | 33 +++
 rtl/pi_pdc_chain_ctrl.sv | 112 +++++++++++
 tb/tb_pi_pdc_chain_ctrl.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/pi_pdc_chain_ctrl_if.sv
// pi_pdc_chain_ctrl_if -- handshake and pad-chain bundle for pi_pdc_chain_ctrl.
//   wr_data/wr_valid/wr_ready : word to shift into the chain (bit 0 first)
//   rd_data/rd_valid/rd_ready : chain contents captured during the last shift
//   abort                     : terminate an in-flight shift
//   chain_sc_in/chain_sc_out  : serial data to first pad / from last pad
//   chain_shift_en            : chain shifts on every cycle this is high
//   busy                      : controller not idle
// slave modport = controller side, master modport = requester/pad side.
interface pi_pdc_chain_ctrl_if #(
  parameter int CHAIN_LEN = 16
);
  logic [CHAIN_LEN-1:0] wr_data;
  logic                 wr_valid;
  logic                 wr_ready;
  logic [CHAIN_LEN-1:0] rd_data;
  logic                 rd_valid;
  logic                 rd_ready;
  logic                 abort;
  logic                 chain_sc_in;
  logic                 chain_sc_out;
  logic                 chain_shift_en;
  logic                 busy;

  modport slave (
    input  wr_data, wr_valid, rd_ready, abort, chain_sc_out,
    output wr_ready, rd_data, rd_valid, chain_sc_in, chain_shift_en, busy
  );

  modport master (
    output wr_data, wr_valid, rd_ready, abort, chain_sc_out,
    input  wr_ready, rd_data, rd_valid, chain_sc_in, chain_shift_en, busy
  );
endinterface

// File: rtl/pi_pdc_chain_ctrl.sv
// pi_pdc_chain_ctrl -- drives a CHAIN_LEN-long pad scan chain.
// A written word is shifted out bit 0 first while the bits returning from the
// last pad are captured into the same bit positions; after CHAIN_LEN shift
// cycles the capture is offered on the read handshake.
// Ports:
//   pi_pdc_chain_ctrl_clk   : clock, rising edge
//   pi_pdc_chain_ctrl_reset : synchronous, active-high reset
//   bus                     : pi_pdc_chain_ctrl_if.slave (handshakes + chain)
module pi_pdc_chain_ctrl #(
  parameter int CHAIN_LEN = 16
) (
  input  logic                  pi_pdc_chain_ctrl_clk,
  input  logic                  pi_pdc_chain_ctrl_reset,
  pi_pdc_chain_ctrl_if.slave    bus
);
  localparam int CW = $clog2(CHAIN_LEN);

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

  state_t               r_state;
  logic [CW-1:0]        r_cnt;
  logic [CHAIN_LEN-1:0] r_sr;
  logic [CHAIN_LEN-1:0] r_cap;
  logic                 r_wr_ready;
  logic                 r_rd_valid;
  logic                 r_shift_en;
  logic                 r_sc_in;
  logic                 r_busy;

  logic [CW-1:0]        w_cnt_nx;
  logic                 w_last;

  assign w_cnt_nx = r_cnt + CW'(1);
  assign w_last   = (r_cnt == CW'(CHAIN_LEN-1));

  // Outputs are registered alongside the state; r_sc_in is preloaded with the
  // bit that the next SHIFT cycle must present.
  always_ff @(posedge pi_pdc_chain_ctrl_clk) begin
    if (pi_pdc_chain_ctrl_reset) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_sr       <= '0;
      r_cap      <= '0;
      r_wr_ready <= 1'b1;
      r_rd_valid <= 1'b0;
      r_shift_en <= 1'b0;
      r_sc_in    <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.wr_valid) begin
            r_state    <= S_SHIFT;
            r_sr       <= bus.wr_data;
            r_cnt      <= '0;
            r_wr_ready <= 1'b0;
            r_busy     <= 1'b1;
            r_shift_en <= 1'b1;
            r_sc_in    <= bus.wr_data[0];
          end
        end
        S_SHIFT: begin
          // The chain shifts at this edge regardless of abort, so the
          // returning bit is still recorded.
          r_cap[r_cnt] <= bus.chain_sc_out;
          if (bus.abort) begin
            // Abort wins over the final-cycle transition; partial capture
            // is kept but never presented.
            r_state    <= S_IDLE;
            r_shift_en <= 1'b0;
            r_sc_in    <= 1'b0;
            r_busy     <= 1'b0;
            r_wr_ready <= 1'b1;
          end else if (w_last) begin
            r_state    <= S_DONE;
            r_shift_en <= 1'b0;
            r_sc_in    <= 1'b0;
            r_rd_valid <= 1'b1;
          end else begin
            r_cnt   <= w_cnt_nx;
            r_sc_in <= r_sr[w_cnt_nx];
          end
        end
        S_DONE: begin
          // wr_ready stays low here, so no write can coincide with the
          // return to IDLE.
          if (bus.rd_ready) begin
            r_state    <= S_IDLE;
            r_rd_valid <= 1'b0;
            r_busy     <= 1'b0;
            r_wr_ready <= 1'b1;
          end
        end
        default: begin
          r_state    <= S_IDLE;
          r_rd_valid <= 1'b0;
          r_shift_en <= 1'b0;
          r_sc_in    <= 1'b0;
          r_busy     <= 1'b0;
          r_wr_ready <= 1'b1;
        end
      endcase
    end
  end

  assign bus.wr_ready       = r_wr_ready;
  assign bus.rd_valid       = r_rd_valid;
  assign bus.rd_data        = r_cap;
  assign bus.chain_shift_en = r_shift_en;
  assign bus.chain_sc_in    = r_sc_in;
  assign bus.busy           = r_busy;
endmodule

// File: tb/tb_pi_pdc_chain_ctrl.sv
// Bench for pi_pdc_chain_ctrl: a 16-long instance checked every cycle against
// a transaction-level model, plus directed literal checks, and a 2-long
// instance for the minimum chain length.
module tb_pi_pdc_chain_ctrl;
  localparam int L  = 16;
  localparam int L2 = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pi_pdc_chain_ctrl_if #(.CHAIN_LEN(L))  bus ();
  pi_pdc_chain_ctrl_if #(.CHAIN_LEN(L2)) bus2 ();

  pi_pdc_chain_ctrl #(.CHAIN_LEN(L)) dut (
    .pi_pdc_chain_ctrl_clk   (clk),
    .pi_pdc_chain_ctrl_reset (rst),
    .bus                     (bus.slave)
  );

  pi_pdc_chain_ctrl #(.CHAIN_LEN(L2)) dut2 (
    .pi_pdc_chain_ctrl_clk   (clk),
    .pi_pdc_chain_ctrl_reset (rst),
    .bus                     (bus2.slave)
  );

  // Pad chains held as words: bit i is what the controller reads back as
  // capture bit i, i.e. bit 0 is the last pad. New bits enter at the MSB.
  logic [L-1:0]  ch  = '0;
  logic [L2-1:0] ch2 = '0;
  assign bus.chain_sc_out  = ch[0];
  assign bus2.chain_sc_out = ch2[0];
  always @(posedge clk) begin
    if (bus.chain_shift_en)  ch  <= {bus.chain_sc_in, ch[L-1:1]};
    if (bus2.chain_shift_en) ch2 <= {bus2.chain_sc_in, ch2[L2-1:1]};
  end

  int nchk = 0;
  int nerr = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction model: phase 0 idle, 1 shifting bit m_k of m_w, 2 holding
  // result m_rd. A full shift returns whatever the chain held at transfer.
  int           m_ph    = 0;
  int           m_k     = 0;
  logic [L-1:0] m_w     = '0;
  logic [L-1:0] m_rd    = '0;
  bit           m_fresh = 1'b0;
  bit           chk_en  = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      m_ph = 0; m_k = 0; m_fresh = 1'b1; chk_en = 1'b1;
    end else if (m_ph == 0) begin
      if (bus.wr_valid) begin
        m_w = bus.wr_data; m_rd = ch; m_k = 0; m_ph = 1; m_fresh = 1'b0;
      end
    end else if (m_ph == 1) begin
      if (bus.abort)         m_ph = 0;
      else if (m_k == L - 1) m_ph = 2;
      else                   m_k++;
    end else begin
      if (bus.rd_ready) m_ph = 0;
    end
  end

  int se_cnt  = 0;
  bit rv_seen = 1'b0;

  always @(negedge clk) begin
    if (bus.chain_shift_en) se_cnt++;
    if (bus.rd_valid)       rv_seen = 1'b1;
    if (chk_en) begin
      chk("wr_ready", 64'(bus.wr_ready),       64'(m_ph == 0));
      chk("busy",     64'(bus.busy),           64'(m_ph != 0));
      chk("shift_en", 64'(bus.chain_shift_en), 64'(m_ph == 1));
      chk("sc_in",    64'(bus.chain_sc_in),    64'((m_ph == 1) ? m_w[m_k] : 1'b0));
      chk("rd_valid", 64'(bus.rd_valid),       64'(m_ph == 2));
      if (m_ph == 2) begin
        chk("rd_data", 64'(bus.rd_data), 64'(m_rd));
        chk("chain",   64'(ch),          64'(m_w));
      end
      if (m_fresh) chk("rd_data_rst", 64'(bus.rd_data), 64'(0));
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin @(posedge clk); #2; end
  endtask

  // Writes d (controller assumed idle); lat = cycle number after the
  // transfer edge on which rd_valid first appears (bounded).
  task automatic wr16(input logic [L-1:0] d, output int lat);
    bus.wr_data = d; bus.wr_valid = 1'b1; se_cnt = 0; rv_seen = 1'b0;
    cyc(1);
    bus.wr_valid = 1'b0;
    lat = 1;
    while (!bus.rd_valid && lat < 100) begin cyc(1); lat++; end
  endtask

  task automatic rd16();
    bus.rd_ready = 1'b1; cyc(1); bus.rd_ready = 1'b0;
  endtask

  task automatic wr2(input logic [L2-1:0] d, output int lat);
    bus2.wr_data = d; bus2.wr_valid = 1'b1;
    cyc(1);
    bus2.wr_valid = 1'b0;
    lat = 1;
    while (!bus2.rd_valid && lat < 100) begin cyc(1); lat++; end
  endtask

  task automatic abort_at(input int k, input int exp_se);
    bus.wr_data = L'($urandom); bus.wr_valid = 1'b1; se_cnt = 0; rv_seen = 1'b0;
    cyc(1);
    bus.wr_valid = 1'b0;
    cyc(k);
    bus.abort = 1'b1;
    cyc(1);
    bus.abort = 1'b0;
    chk("abort_idle", 64'(bus.busy), 64'(0));
    cyc(3);
    chk("abort_se_cnt", 64'(se_cnt), 64'(exp_se));
    chk("abort_no_rv",  64'(rv_seen), 64'(0));
  endtask

  initial begin
    int lat;
    logic [L-1:0] hold;
    bus.wr_data = '0; bus.wr_valid = 1'b0; bus.rd_ready = 1'b0; bus.abort = 1'b0;
    bus2.wr_data = '0; bus2.wr_valid = 1'b0; bus2.rd_ready = 1'b0; bus2.abort = 1'b0;
    rst = 1'b1;
    cyc(2);
    rst = 1'b0;

    chk("rst_wr_ready", 64'(bus.wr_ready), 64'(1));
    chk("rst_rd_valid", 64'(bus.rd_valid), 64'(0));
    chk("rst_rd_data",  64'(bus.rd_data),  64'(0));
    chk("rst_busy",     64'(bus.busy),     64'(0));

    // basic shift into an all-zero chain
    wr16(16'hA5C3, lat);
    chk("basic_latency", 64'(lat),          64'(17));
    chk("basic_se_cnt",  64'(se_cnt),       64'(16));
    chk("basic_rd_data", 64'(bus.rd_data),  64'(16'h0000));
    rd16();

    // read-back of the previous word, then backpressure
    wr16(16'h1234, lat);
    chk("rb_rd_data", 64'(bus.rd_data), 64'(16'hA5C3));
    chk("rb_chain",   64'(ch),          64'(16'h1234));
    hold = bus.rd_data;
    bus.wr_valid = 1'b1; bus.wr_data = 16'hFFFF;
    for (int i = 0; i < 20; i++) begin
      cyc(1);
      chk("bp_rd_valid", 64'(bus.rd_valid), 64'(1));
      chk("bp_rd_data",  64'(bus.rd_data),  64'(hold));
      chk("bp_wr_ready", 64'(bus.wr_ready), 64'(0));
    end
    bus.wr_valid = 1'b0; bus.rd_ready = 1'b1;
    cyc(1);
    bus.rd_ready = 1'b0;
    chk("bp_release_rv", 64'(bus.rd_valid), 64'(0));
    chk("bp_release_wr", 64'(bus.wr_ready), 64'(1));
    chk("bp_chain",      64'(ch),           64'(16'h1234));

    // abort mid-shift and on the final shift cycle
    abort_at(5, 6);
    abort_at(15, 16);

    // reset in the middle of a shift
    bus.wr_data = 16'hC0DE; bus.wr_valid = 1'b1;
    cyc(1);
    bus.wr_valid = 1'b0;
    cyc(8);
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
    chk("mrst_wr_ready", 64'(bus.wr_ready),       64'(1));
    chk("mrst_rd_valid", 64'(bus.rd_valid),       64'(0));
    chk("mrst_rd_data",  64'(bus.rd_data),        64'(0));
    chk("mrst_sc_in",    64'(bus.chain_sc_in),    64'(0));
    chk("mrst_shift_en", 64'(bus.chain_shift_en), 64'(0));
    chk("mrst_busy",     64'(bus.busy),           64'(0));
    wr16(16'h5A5A, lat);
    chk("mrst_latency", 64'(lat), 64'(17));
    rd16();
    chk("mrst_chain", 64'(ch), 64'(16'h5A5A));

    // randomized traffic, every cycle checked by the model
    for (int i = 0; i < 4000; i++) begin
      bus.wr_valid = 1'($urandom_range(0, 1));
      bus.wr_data  = L'($urandom);
      bus.rd_ready = ($urandom_range(0, 2) == 0);
      bus.abort    = ($urandom_range(0, 19) == 0);
      rst          = ($urandom_range(0, 299) == 0);
      cyc(1);
    end
    bus.wr_valid = 1'b0; bus.rd_ready = 1'b0; bus.abort = 1'b0;
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
    cyc(1);

    // minimum-length chain
    wr2(2'b10, lat);
    chk("min_lat1",  64'(lat),           64'(3));
    chk("min_rd1",   64'(bus2.rd_data),  64'(2'b00));
    bus2.rd_ready = 1'b1; cyc(1); bus2.rd_ready = 1'b0;
    wr2(2'b10, lat);
    chk("min_lat2",  64'(lat),           64'(3));
    chk("min_rd2",   64'(bus2.rd_data),  64'(2'b10));
    chk("min_chain", 64'(ch2),           64'(2'b10));
    bus2.rd_ready = 1'b1; cyc(1); bus2.rd_ready = 1'b0;
    chk("min_idle",  64'(bus2.wr_ready), 64'(1));

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end
endmodule
